// File: rtl/tail_light_pkg.sv
// Shared types and the turn-lamp pattern helper for the tail light sequencer.
package tail_light_pkg;

    localparam int unsigned MAX_LAMPS = 8;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ
    } mode_t;

    // Thermometer code: step k < n_lamps lights the lowest k+1 lamps, step n_lamps is dark.
    function automatic logic [MAX_LAMPS-1:0] lamp_pattern(input int unsigned step,
                                                          input int unsigned n_lamps);
        logic [MAX_LAMPS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            if ((step < n_lamps) && (i <= step)) begin
                v[i[2:0]] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tl_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, tick marks the last count.
module tl_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Tail light sequencer: turn thermometer sweeps, hazard flash and brake fill, registered lamps.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int unsigned N_LAMPS  = 3,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    input  logic               brake,
    output logic [N_LAMPS-1:0] light_l,
    output logic [N_LAMPS-1:0] light_r,
    output logic               active
);

    localparam int unsigned SW = $clog2(N_LAMPS + 1);

    generate
        if ((N_LAMPS < 2) || (N_LAMPS > MAX_LAMPS)) begin : g_bad_n_lamps
            $error("tail_light_seq: N_LAMPS must be in 2..8");
        end
        if ((TICK_DIV < 1) || (TICK_DIV > 65536)) begin : g_bad_tick_div
            $error("tail_light_seq: TICK_DIV must be in 1..65536");
        end
    endgenerate

    mode_t               mode_q, mode_d, req_mode;
    logic [SW-1:0]       step_q, step_d;
    logic [N_LAMPS-1:0]  light_l_d, light_r_d, brake_fill;
    logic                haz_req, tick, pre_clear, pre_en;

    assign haz_req    = hazard | (left & right);
    assign brake_fill = brake ? '1 : '0;

    tl_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(pre_clear),
        .en   (pre_en),
        .tick (tick)
    );

    // Mode chosen whenever a sequence is allowed to (re)start.
    always_comb begin
        req_mode = IDLE;
        if (haz_req) begin
            req_mode = HAZ;
        end else if (left) begin
            req_mode = LEFT;
        end else if (right) begin
            req_mode = RIGHT;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        step_d    = step_q;
        pre_en    = (mode_q != IDLE);
        pre_clear = 1'b0;
        unique case (mode_q)
            IDLE: begin
                mode_d    = req_mode;
                step_d    = '0;
                pre_clear = 1'b1;
            end
            LEFT, RIGHT: begin
                if (haz_req) begin
                    mode_d    = HAZ;
                    step_d    = '0;
                    pre_clear = 1'b1;
                end else if (tick) begin
                    if (step_q == SW'(N_LAMPS)) begin
                        mode_d = req_mode;
                        step_d = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            HAZ: begin
                if (tick) begin
                    if (step_q == '0) begin
                        step_d = SW'(1);
                    end else begin
                        mode_d = req_mode;
                        step_d = '0;
                    end
                end
            end
            default: begin
                mode_d = IDLE;
                step_d = '0;
            end
        endcase
    end

    // Lamp image of the current state; registered below for the fixed one-cycle latency.
    always_comb begin
        light_l_d = brake_fill;
        light_r_d = brake_fill;
        unique case (mode_q)
            LEFT:    light_l_d = N_LAMPS'(lamp_pattern(32'(step_q), N_LAMPS));
            RIGHT:   light_r_d = N_LAMPS'(lamp_pattern(32'(step_q), N_LAMPS));
            HAZ: begin
                light_l_d = (step_q == '0) ? '1 : '0;
                light_r_d = (step_q == '0) ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= IDLE;
            step_q  <= '0;
            light_l <= '0;
            light_r <= '0;
            active  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            light_l <= light_l_d;
            light_r <= light_r_d;
            active  <= (mode_q != IDLE);
        end
    end

endmodule
